readptr_empty: RTL
==================

// Module: readptr_empty
// PURPOSE
//  Read-domain pointer/flag logic of the async FIFO; counterpart of the write-side pointer/full block.
//  Generates the binary read address for the dual-port memory and the Gray read pointer sent to the write domain.
//  Derives registered empty, almost-empty, occupancy and underflow status from the already-synchronised write pointer.
//  Emits a one-cycle rvalid strobe aligned with the memory's 1-cycle read data.
// PARAMETERS
//  A_Size    8   address width; depth = 2**A_Size; pointers are A_Size+1 bits (extra wrap bit)
//  AE_Level  16  almost-empty threshold in words; aempty=1 when occupancy <= AE_Level
// PORTS
//  r_clk        input   1          read clock; the only clock in this block
//  r_rst        input   1          reset, asynchronous, active-high
//  r_inc        input   1          read request from consumer
//  wptr_sync    input   A_Size+1   Gray write pointer, already 2-FF synchronised into r_clk
//  raddr        output  A_Size+1   binary read pointer; memory index = raddr[A_Size-1:0]
//  rptr         output  A_Size+1   Gray read pointer, registered, to write-domain synchroniser
//  rempty       output  1          FIFO empty, registered
//  aempty       output  1          occupancy <= AE_Level, registered
//  rcount       output  A_Size+1   occupancy in words (0..2**A_Size), registered
//  rvalid       output  1          memory read data valid this cycle
//  r_underflow  output  1          sticky: read requested while empty
// BEHAVIOUR
//  - Reset (r_rst=1, async, takes effect immediately, also mid-operation): raddr=0, rptr=0, rempty=1,
//    aempty=1, rcount=0, rvalid=0, r_underflow=0. Held while r_rst=1.
//  - rd_ok = r_inc & !rempty. next_raddr = raddr + rd_ok (mod 2**(A_Size+1), natural wrap).
//  - next_rptr = (next_raddr >> 1) ^ next_raddr. raddr<=next_raddr, rptr<=next_rptr every r_clk.
//  - bin_wptr = Gray-to-binary(wptr_sync) via MSB-down XOR chain.
//  - next_empty = (next_rptr == wptr_sync); rempty <= next_empty. Empty asserts on the same edge
//    that consumes the last word; no read is accepted in the cycle after.
//  - next_count = bin_wptr - next_raddr, (A_Size+1)-bit mod arithmetic; rcount <= next_count.
//    Max legal value 2**A_Size (full); values above are impossible and flagged by assertion.
//  - aempty <= (next_count <= AE_Level).
//  - rvalid <= rd_ok: exactly 1 cycle after each accepted read; never set on a rejected read.
//  - r_underflow <= r_underflow | (r_inc & rempty); cleared only by reset. Rejected reads do not
//    move raddr/rptr.
//  - Simultaneous write arrival and last read: flags use the current-cycle wptr_sync, so if
//    wptr_sync advances in the same cycle the last word is read, rempty stays 0.
//  - Wrap: raddr 2**(A_Size+1)-1 -> 0; rptr Gray wraps with single-bit change; count math unaffected.
//  - Embedded assertions (disable iff r_rst): rptr==bin2gray(raddr); rptr changes by <=1 bit
//    per cycle; rempty |-> rcount==0; rcount <= 2**A_Size; rvalid |-> $past(!rempty & r_inc).
// TESTING (A_Size=8, AE_Level=16)
//  1 Reset mid-run at raddr=37, rempty=0 -> all outputs immediately at reset values, no r_clk needed.
//  2 wptr_sync=9'h002 (bin 3) from reset -> next edge rempty=0, rcount=3, aempty=1; r_inc 3 cycles
//    -> raddr 1,2,3, rvalid high 3 cycles lagging by 1, rempty=1 on edge raddr becomes 3.
//  3 rempty=1, r_inc=1 one cycle -> raddr/rptr unchanged, rvalid=0, r_underflow=1 next edge,
//    stays 1 until r_rst.
//  4 raddr=9'h1FF, wptr_sync=gray(1)=9'h001 (rcount=2): two reads -> raddr 0 then 1, rptr 9'h100->
//    9'h000->9'h001, rempty=1 after second read.
//  5 raddr=0, wptr_sync=9'h180 (bin 256) -> rcount=256, rempty=0, aempty=0; drain 240 reads ->
//    aempty=1 when rcount=16.
//  6 rcount=1, r_inc=1 same cycle wptr_sync 9'h001->9'h003 -> rempty stays 0, rcount=1, rvalid=1 next.

Source files
------------

// File: rtl/readptr_empty.sv
// Read-side pointer and status logic of the asynchronous FIFO.
// Produces the binary read address, the Gray read pointer and registered empty/occupancy flags.
module readptr_empty #(
  parameter int unsigned A_Size   = 8,
  parameter int unsigned AE_Level = 16
) (
  input  logic              r_clk,
  input  logic              r_rst,
  input  logic              r_inc,
  input  logic [A_Size:0]   wptr_sync,
  output logic [A_Size:0]   raddr,
  output logic [A_Size:0]   rptr,
  output logic              rempty,
  output logic              aempty,
  output logic [A_Size:0]   rcount,
  output logic              rvalid,
  output logic              r_underflow
);

  localparam int unsigned PW = A_Size + 1;
  localparam logic [PW-1:0] FULL_CNT = {1'b1, {A_Size{1'b0}}};
  localparam logic [PW-1:0] AE_CNT   = PW'(AE_Level);

  logic          rd_ok;
  logic [PW-1:0] next_raddr;
  logic [PW-1:0] next_rptr;
  logic [PW-1:0] bin_wptr;
  logic [PW-1:0] next_count;
  logic          next_empty;
  logic          next_aempty;
  logic          next_underflow;

  // Next-state pointer arithmetic and flag derivation from the synchronised write pointer
  always_comb begin
    rd_ok          = 1'b0;
    next_raddr     = raddr;
    next_rptr      = rptr;
    bin_wptr       = '0;
    next_count     = '0;
    next_empty     = 1'b1;
    next_aempty    = 1'b1;
    next_underflow = r_underflow;

    rd_ok      = r_inc & ~rempty;
    next_raddr = raddr + PW'(rd_ok);
    next_rptr  = (next_raddr >> 1) ^ next_raddr;

    bin_wptr[PW-1] = wptr_sync[PW-1];
    for (int i = int'(PW) - 2; i >= 0; i--) begin
      bin_wptr[i] = bin_wptr[i+1] ^ wptr_sync[i];
    end

    next_empty     = (next_rptr == wptr_sync);
    next_count     = bin_wptr - next_raddr;
    next_aempty    = (next_count <= AE_CNT);
    next_underflow = r_underflow | (r_inc & rempty);
  end

  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      raddr       <= '0;
      rptr        <= '0;
      rempty      <= 1'b1;
      aempty      <= 1'b1;
      rcount      <= '0;
      rvalid      <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      raddr       <= next_raddr;
      rptr        <= next_rptr;
      rempty      <= next_empty;
      aempty      <= next_aempty;
      rcount      <= next_count;
      rvalid      <= rd_ok;
      r_underflow <= next_underflow;
    end
  end

  // Structural invariants of the read pointer and status flags
  a_gray_match: assert property (@(posedge r_clk) disable iff (r_rst)
    rptr == ((raddr >> 1) ^ raddr));

  a_gray_onebit: assert property (@(posedge r_clk) disable iff (r_rst)
    $countones(rptr ^ $past(rptr)) <= 1);

  a_empty_count: assert property (@(posedge r_clk) disable iff (r_rst)
    rempty |-> (rcount == '0));

  a_count_max: assert property (@(posedge r_clk) disable iff (r_rst)
    rcount <= FULL_CNT);

  a_valid_src: assert property (@(posedge r_clk) disable iff (r_rst)
    rvalid |-> $past(!rempty & r_inc));

endmodule
